pipe_stage_hs: RTL and testbench

//  Parametrised handshaked pipeline-stage register for inter-stage boundaries (decode->execute and later).

---
 rtl/pipe_stage_hs_pkg.sv | 19 +
 rtl/pipe_stage_hs_if.sv | 12 +
 rtl/pipe_stage_hs_sat_cnt.sv | 30 +++
 rtl/pipe_stage_hs.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_hs.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the handshaked pipeline stage: state encodings
// (reused by other stages) and the flush drop-count helper.
package pipe_stage_hs_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_HALF  = 2'd1;
    localparam state_t ST_FULL  = 2'd2;

    // Beats lost on a flush: everything held, minus the beat leaving this
    // cycle, plus the beat entering this cycle. Never exceeds 3.
    function automatic logic [1:0] drop_incr(input logic [1:0] occ,
                                             input logic       in_fire,
                                             input logic       out_fire);
        return occ + {1'b0, in_fire} - {1'b0, out_fire};
    endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready/data bundle for one side of a pipeline stage.
// master drives valid/data, slave drives ready.
interface pipe_stage_hs_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_hs_sat_cnt.sv
// pipe_sat_cnt: CNT_W-bit counter that adds 0..3 when enabled and sticks
// at all-ones instead of wrapping.
module pipe_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W:0] sum;

    assign sum = {1'b0, cnt} + (CNT_W+1)'(inc);

    // Accumulate, clamping to all-ones on carry out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            if (sum[CNT_W]) begin
                cnt <= '1;
            end else begin
                cnt <= sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshaked pipeline-stage register with flush and a
// saturating count of flushed beats. Payload is opaque.
// Build option: PIPE_SKID_EN adds a second (skid) entry so in_ready is a
// flop; without it in_ready is combinational from out_ready.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid=0, out_data=0
// ST_HALF  | main register valid
// ST_FULL  | main and skid valid, upstream held off (skid build only)
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_hs_if.slave   up,
    pipe_stage_hs_if.master  dn,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] drop_cnt
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              out_valid;
    logic              in_fire, out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign dn.valid  = out_valid;
    assign dn.data   = main_q;      // main is cleared whenever empty
    assign in_fire   = up.valid & up.ready;
    assign out_fire  = out_valid & dn.ready;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;

    assign up.ready = in_ready_q;
    assign occ      = state_q;

    // Three-state skid FSM; flush overrides everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_HALF;
                        main_d  = up.data;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        main_d = up.data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = up.data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = '0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_HALF;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Skid entry and the registered ready, which looks one state ahead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end
`else
    logic rdy_en_q;

    assign up.ready = rdy_en_q & (~out_valid | dn.ready);
    assign occ      = {1'b0, out_valid};

    // Single-entry register: load on accept, clear on drain or flush.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
        end else if (in_fire) begin
            state_d = ST_HALF;
            main_d  = up.data;
        end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = '0;
        end
    end

    // Holds ready low through reset and for the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end
`endif

    // Main entry and FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    // An offered-but-not-accepted beat stays with upstream, so only
    // in_fire counts toward drops.
    pipe_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush),
        .inc   (drop_incr(occ, in_fire, out_fire)),
        .cnt   (drop_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed and random bench for pipe_stage_hs; expectations follow
// PIPE_SKID_EN when the design is built with it.
module tb_pipe_stage_hs;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] occ;
    logic [7:0] drop_cnt;
    logic       flush2;
    logic [1:0] occ2;
    logic [1:0] drop2;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_drop = 0;

    pipe_stage_hs_if #(.DATA_W(32)) up_if ();
    pipe_stage_hs_if #(.DATA_W(32)) dn_if ();
    pipe_stage_hs_if #(.DATA_W(32)) up2_if ();
    pipe_stage_hs_if #(.DATA_W(32)) dn2_if ();

    pipe_stage_hs #(.DATA_W(32), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .up       (up_if),
        .dn       (dn_if),
        .occ      (occ),
        .drop_cnt (drop_cnt)
    );

    pipe_stage_hs #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush2),
        .up       (up2_if),
        .dn       (dn2_if),
        .occ      (occ2),
        .drop_cnt (drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        up_if.valid = 1'b1;
        up_if.data  = 32'hDEADBEEF;
        dn_if.ready = 1'b0;
        tick();
        tick();
        n_tests++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", dn_if.valid); end
        n_tests++; if (dn_if.data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", dn_if.data); end
        n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        n_tests++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", up_if.ready); end
        n_tests++; if (drop2 !== 2'd0) begin n_fail++; $display("FAIL reset_drop_cnt_sat: got %0d expected 0", drop2); end
        reset = 1'b1;
        #1;
        n_tests++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_pre_edge: got %b expected 0", up_if.ready); end
        tick();
        n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready_post_edge: got %b expected 1", up_if.ready); end
        n_tests++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL release_no_early_accept: got %b expected 0", dn_if.valid); end
        tick();
        n_tests++; if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL release_first_accept_valid: got %b expected 1", dn_if.valid); end
        n_tests++; if (dn_if.data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL release_first_accept_data: got %h expected deadbeef", dn_if.data); end
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        tick();
        n_tests++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL release_drain: got %b expected 0", dn_if.valid); end
    endtask

    task automatic test_stream();
        dn_if.ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            up_if.valid = 1'b1;
            up_if.data  = 32'(k);
            #1;
            n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, up_if.ready); end
            tick();
            n_tests++; if (dn_if.data !== 32'(k) || dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL stream_out[%0d]: got valid %b data %h expected valid 1 data %h", k, dn_if.valid, dn_if.data, 32'(k)); end
            n_tests++; if (occ !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d expected 1", k, occ); end
        end
        up_if.valid = 1'b0;
        tick();
        n_tests++; if (dn_if.valid !== 1'b0 || dn_if.data !== 32'h0) begin n_fail++; $display("FAIL stream_bubble: got valid %b data %h expected valid 0 data 0", dn_if.valid, dn_if.data); end
    endtask

    task automatic test_stall();
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'd5;
        tick();
        up_if.data  = 32'd6;
        #1;
`ifdef PIPE_SKID_EN
        n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_half: got %b expected 1", up_if.ready); end
        tick();
        up_if.valid = 1'b0;
        #1;
        n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL stall_occ_full: got %0d expected 2", occ); end
        n_tests++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_full: got %b expected 0", up_if.ready); end
        n_tests++; if (dn_if.data !== 32'd5) begin n_fail++; $display("FAIL stall_hold_a: got %h expected 5", dn_if.data); end
        dn_if.ready = 1'b1;
        tick();
        n_tests++; if (dn_if.data !== 32'd6 || occ !== 2'd1) begin n_fail++; $display("FAIL stall_second_b: got data %h occ %0d expected data 6 occ 1", dn_if.data, occ); end
        tick();
        n_tests++; if (dn_if.valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL stall_drained: got valid %b occ %0d expected 0 0", dn_if.valid, occ); end
`else
        n_tests++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_held: got %b expected 0", up_if.ready); end
        tick();
        n_tests++; if (occ !== 2'd1 || dn_if.data !== 32'd5) begin n_fail++; $display("FAIL stall_hold_a: got occ %0d data %h expected occ 1 data 5", occ, dn_if.data); end
        n_tests++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL stall_b_held_off: got %b expected 0", up_if.ready); end
        dn_if.ready = 1'b1;
        #1;
        n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_follows_out: got %b expected 1", up_if.ready); end
        tick();
        up_if.valid = 1'b0;
        #1;
        n_tests++; if (dn_if.data !== 32'd6 || occ !== 2'd1) begin n_fail++; $display("FAIL stall_second_b: got data %h occ %0d expected data 6 occ 1", dn_if.data, occ); end
        tick();
        n_tests++; if (dn_if.valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL stall_drained: got valid %b occ %0d expected 0 0", dn_if.valid, occ); end
`endif
    endtask

    task automatic fill_stage();
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'd10;
        tick();
`ifdef PIPE_SKID_EN
        up_if.data  = 32'd11;
        tick();
`endif
    endtask

    task automatic test_flush();
        // case 1: full, downstream stalled, beat offered but not accepted
        fill_stage();
        up_if.data = 32'd12;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        up_if.valid = 1'b0;
`ifdef PIPE_SKID_EN
        exp_drop += 2;
`else
        exp_drop += 1;
`endif
        n_tests++; if (occ !== 2'd0 || dn_if.valid !== 1'b0 || dn_if.data !== 32'h0) begin n_fail++; $display("FAIL flush_stalled_empty: got occ %0d valid %b data %h expected 0 0 0", occ, dn_if.valid, dn_if.data); end
        n_tests++; if (drop_cnt !== exp_drop[7:0]) begin n_fail++; $display("FAIL flush_stalled_drop: got %0d expected %0d", drop_cnt, exp_drop); end
        n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_back: got %b expected 1", up_if.ready); end
        // case 2: full, downstream taking a beat in the flush cycle
        fill_stage();
        dn_if.ready = 1'b1;
        up_if.data  = 32'd12;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        up_if.valid = 1'b0;
        dn_if.ready = 1'b0;
        exp_drop += 1;
        n_tests++; if (drop_cnt !== exp_drop[7:0]) begin n_fail++; $display("FAIL flush_delivering_drop: got %0d expected %0d", drop_cnt, exp_drop); end
        n_tests++; if (occ !== 2'd0 || dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_delivering_empty: got occ %0d valid %b expected 0 0", occ, dn_if.valid); end
        // case 3: empty stage, beat accepted in the flush cycle
        up_if.valid = 1'b1;
        up_if.data  = 32'd13;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        up_if.valid = 1'b0;
        exp_drop += 1;
        n_tests++; if (drop_cnt !== exp_drop[7:0]) begin n_fail++; $display("FAIL flush_accept_empty_drop: got %0d expected %0d", drop_cnt, exp_drop); end
        n_tests++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept_squashed: got %b expected 0", dn_if.valid); end
`ifdef PIPE_SKID_EN
        // case 4: one held plus one accepted in the flush cycle
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'd14;
        tick();
        up_if.data  = 32'd15;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        up_if.valid = 1'b0;
        exp_drop += 2;
        n_tests++; if (drop_cnt !== exp_drop[7:0]) begin n_fail++; $display("FAIL flush_half_accept_drop: got %0d expected %0d", drop_cnt, exp_drop); end
`endif
    endtask

    task automatic test_saturation();
        int exp2 = 0;
        int inc;
`ifdef PIPE_SKID_EN
        inc = 2;
`else
        inc = 1;
`endif
        for (int k = 0; k < 4; k++) begin
            dn2_if.ready = 1'b0;
            up2_if.valid = 1'b1;
            up2_if.data  = 32'h100 + 32'(k);
            tick();
`ifdef PIPE_SKID_EN
            up2_if.data  = 32'h200 + 32'(k);
            tick();
`endif
            up2_if.valid = 1'b0;
            flush2 = 1'b1;
            tick();
            flush2 = 1'b0;
            exp2 = (exp2 + inc > 3) ? 3 : exp2 + inc;
            n_tests++; if (drop2 !== exp2[1:0]) begin n_fail++; $display("FAIL sat_drop[%0d]: got %0d expected %0d", k, drop2, exp2); end
            n_tests++; if (occ2 !== 2'd0) begin n_fail++; $display("FAIL sat_occ[%0d]: got %0d expected 0", k, occ2); end
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] seq = 32'h1000;
        logic [31:0] exp_d;
        logic        exp_rdy, inf, outf;
        bit          pending = 0;
        int          dropped = 0;
        flush = 1'b0;
        up_if.valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pending && $urandom_range(0, 99) < 60) begin
                pending = 1;
                up_if.data = seq;
                seq++;
            end
            up_if.valid = pending;
            dn_if.ready = ($urandom_range(0, 99) < 65);
            flush = ($urandom_range(0, 99) < 5);
            #1;
`ifdef PIPE_SKID_EN
            exp_rdy = (q.size() < 2);
`else
            exp_rdy = (q.size() == 0) || dn_if.ready;
`endif
            exp_d = (q.size() != 0) ? q[0] : 32'h0;
            n_tests++; if (up_if.ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, up_if.ready, exp_rdy); end
            n_tests++; if (dn_if.valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", c, dn_if.valid, q.size() != 0); end
            n_tests++; if (dn_if.data !== exp_d) begin n_fail++; $display("FAIL rand_out_data[%0d]: got %h expected %h", c, dn_if.data, exp_d); end
            n_tests++; if (occ !== 2'(q.size())) begin n_fail++; $display("FAIL rand_occ[%0d]: got %0d expected %0d", c, occ, q.size()); end
            inf  = up_if.valid & up_if.ready;
            outf = dn_if.valid & dn_if.ready;
            if (flush) begin
                dropped += q.size() - int'(outf) + int'(inf);
                q.delete();
            end else begin
                if (outf && q.size() != 0) void'(q.pop_front());
                if (inf) q.push_back(up_if.data);
            end
            if (inf) pending = 0;
            tick();
        end
        flush = 1'b0;
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        tick();
        tick();
        exp_drop = (exp_drop + dropped > 255) ? 255 : exp_drop + dropped;
        n_tests++; if (drop_cnt !== exp_drop[7:0]) begin n_fail++; $display("FAIL rand_drop_total: got %0d expected %0d", drop_cnt, exp_drop); end
        n_tests++; if (dn_if.valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL rand_drained: got valid %b occ %0d expected 0 0", dn_if.valid, occ); end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        flush2 = 1'b0;
        up_if.valid  = 1'b1;
        up_if.data   = 32'hDEADBEEF;
        dn_if.ready  = 1'b0;
        up2_if.valid = 1'b0;
        up2_if.data  = 32'h0;
        dn2_if.ready = 1'b0;
        #2;
        reset = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
